// File: rtl/cpu_defs.sv
// Shared CPU datapath definitions: register/data widths and the buffered
// writeback entry layout used by the GRF write-port arbiter.
package cpu_defs;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  a3;
        logic [DATA_W-1:0] wd;
    } wb_entry_t;

    // r0 is never a real destination, so it never matches anything.
    function automatic logic reg_match(input logic [REG_W-1:0] query,
                                       input logic [REG_W-1:0] stored);
        return (query != ZERO_REG) && (query == stored);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending long-latency writebacks with per-entry live bits,
// a parallel kill-by-address port and two address-match query ports.
module wb_fifo
    import cpu_defs::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     push_live_i,
    input  logic [REG_W-1:0]         push_a3_i,
    input  logic [DATA_W-1:0]        push_wd_i,
    input  logic                     pop_i,
    input  logic                     kill_en_i,
    input  logic [REG_W-1:0]         kill_a3_i,
    input  logic [REG_W-1:0]         q1_a3_i,
    input  logic [REG_W-1:0]         q2_a3_i,
    output logic                     hit1_o,
    output logic                     hit2_o,
    output logic                     head_live_o,
    output logic [REG_W-1:0]         head_a3_o,
    output logic [DATA_W-1:0]        head_wd_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]    live_q, live_d;
    logic [REG_W-1:0]    a3_q [DEPTH];
    logic [DATA_W-1:0]   wd_q [DEPTH];

    logic [AW-1:0]       wr_idx;
    logic [AW-1:0]       rd_idx;
    logic                push_ok;
    logic                pop_ok;

    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign rd_idx  = rd_ptr_q[AW-1:0];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign head_live_o = live_q[rd_idx] && !empty_o;
    assign head_a3_o   = a3_q[rd_idx];
    assign head_wd_o   = wd_q[rd_idx];

    // Live bits are cleared on pop so only occupied slots can ever be live;
    // a same-cycle push overrides the kill because its live bit already
    // accounts for the squash.
    always_comb begin
        live_d = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en_i && (a3_q[i] == kill_a3_i)) begin
                live_d[i] = 1'b0;
            end
        end
        if (pop_ok) begin
            live_d[rd_idx] = 1'b0;
        end
        if (push_ok) begin
            live_d[wr_idx] = push_live_i;
        end
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
    end

    always_comb begin
        hit1_o = 1'b0;
        hit2_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1_o = hit1_o | (live_q[i] & reg_match(q1_a3_i, a3_q[i]));
            hit2_o = hit2_o | (live_q[i] & reg_match(q2_a3_i, a3_q[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            live_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            live_q   <= live_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            a3_q[wr_idx] <= push_a3_i;
            wd_q[wr_idx] <= push_wd_i;
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: pipeline writeback has priority, long-latency results
// are buffered (or bypassed when nothing is waiting), with starvation relief.
module grf_wb_arbiter
    import cpu_defs::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REG_W-1:0]         pipe_a3,
    input  logic [DATA_W-1:0]        pipe_wd,
    input  logic                     lr_valid,
    output logic                     lr_ready,
    input  logic [REG_W-1:0]         lr_a3,
    input  logic [DATA_W-1:0]        lr_wd,
    output logic [REG_W-1:0]         grf_a3,
    output logic [DATA_W-1:0]        grf_wd,
    output logic                     steal,
    input  logic [REG_W-1:0]         rd_a1,
    input  logic [REG_W-1:0]         rd_a2,
    output logic                     pend1,
    output logic                     pend2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic              pipe_wr;
    logic              accept;
    logic              lr_squash;
    logic              lr_real;
    logic              bypass;
    logic              push;
    logic              pop;

    logic              fifo_empty;
    logic              fifo_full;
    logic              head_live;
    logic [REG_W-1:0]  head_a3;
    logic [DATA_W-1:0] head_wd;
    logic              hit1;
    logic              hit2;

    logic [SW-1:0]     starve_q, starve_d;
    logic              steal_q, steal_d;

    assign pipe_wr   = (pipe_a3 != ZERO_REG);
    assign lr_ready  = !fifo_full && !reset;
    assign accept    = lr_valid && lr_ready;
    // A same-cycle pipeline write to the same register is program-younger.
    assign lr_squash = pipe_wr && (lr_a3 == pipe_a3);
    assign lr_real   = accept && (lr_a3 != ZERO_REG);
    assign bypass    = lr_real && !lr_squash && fifo_empty && !pipe_wr;
    assign push      = lr_real && !bypass;
    // Killed heads drain even while the pipeline owns the port.
    assign pop       = !fifo_empty && (!head_live || !pipe_wr);

    assign pend1 = hit1 && !reset;
    assign pend2 = hit2 && !reset;
    assign steal = steal_q;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_live_i (!lr_squash),
        .push_a3_i   (lr_a3),
        .push_wd_i   (lr_wd),
        .pop_i       (pop),
        .kill_en_i   (pipe_wr),
        .kill_a3_i   (pipe_a3),
        .q1_a3_i     (rd_a1),
        .q2_a3_i     (rd_a2),
        .hit1_o      (hit1),
        .hit2_o      (hit2),
        .head_live_o (head_live),
        .head_a3_o   (head_a3),
        .head_wd_o   (head_wd),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (count)
    );

    always_comb begin
        grf_a3 = ZERO_REG;
        grf_wd = '0;
        if (reset) begin
            grf_a3 = ZERO_REG;
        end else if (pipe_wr) begin
            grf_a3 = pipe_a3;
            grf_wd = pipe_wd;
        end else if (head_live) begin
            grf_a3 = head_a3;
            grf_wd = head_wd;
        end else if (bypass) begin
            grf_a3 = lr_a3;
            grf_wd = lr_wd;
        end
    end

    // A non-empty FIFO that does not pop has a live head denied by the pipe.
    always_comb begin
        starve_d = starve_q;
        steal_d  = 1'b0;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (starve_q == SW'(STARVE_MAX - 1)) begin
            starve_d = '0;
            steal_d  = 1'b1;
        end else begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            steal_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            steal_q  <= steal_d;
        end
    end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Randomized + directed bench for grf_wb_arbiter against a queue-based model
// of the buffered writeback stream.
module tb_grf_wb_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    pipe_a3;
    logic [31:0]   pipe_wd;
    logic          lr_valid;
    logic          lr_ready;
    logic [4:0]    lr_a3;
    logic [31:0]   lr_wd;
    logic [4:0]    grf_a3;
    logic [31:0]   grf_wd;
    logic          steal;
    logic [4:0]    rd_a1;
    logic [4:0]    rd_a2;
    logic          pend1;
    logic          pend2;
    logic [CW-1:0] count;

    grf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk      (clk),
        .reset    (reset),
        .pipe_a3  (pipe_a3),
        .pipe_wd  (pipe_wd),
        .lr_valid (lr_valid),
        .lr_ready (lr_ready),
        .lr_a3    (lr_a3),
        .lr_wd    (lr_wd),
        .grf_a3   (grf_a3),
        .grf_wd   (grf_wd),
        .steal    (steal),
        .rd_a1    (rd_a1),
        .rd_a2    (rd_a2),
        .pend1    (pend1),
        .pend2    (pend2),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          live;
        logic [4:0]  a3;
        logic [31:0] wd;
    } ent_t;

    ent_t m_q[$];
    int   m_starve = 0;
    bit   m_steal  = 0;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0]  obs_a3;
    logic [31:0] obs_wd;
    logic        obs_ready, obs_steal, obs_pend1, obs_pend2;
    logic [31:0] obs_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic set_idle();
        reset    = 1'b0;
        pipe_a3  = 5'd0;
        pipe_wd  = 32'd0;
        lr_valid = 1'b0;
        lr_a3    = 5'd0;
        lr_wd    = 32'd0;
        rd_a1    = 5'd0;
        rd_a2    = 5'd0;
    endtask

    function automatic bit model_pend(input logic [4:0] rd);
        bit p = 0;
        foreach (m_q[i]) if (m_q[i].live && rd != 0 && m_q[i].a3 == rd) p = 1;
        return p;
    endfunction

    // One clock: sample at negedge, compare with model, advance model.
    task automatic run_cycle();
        bit          e_ready, acc, squash, byp, hl, popped, nsteal;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        int          sz;
        @(negedge clk);
        obs_a3    = grf_a3;
        obs_wd    = grf_wd;
        obs_ready = lr_ready;
        obs_steal = steal;
        obs_pend1 = pend1;
        obs_pend2 = pend2;
        obs_count = 32'(count);

        sz      = m_q.size();
        e_ready = !reset && (sz < DEPTH);
        acc     = lr_valid && e_ready;
        squash  = (pipe_a3 != 0) && (lr_a3 == pipe_a3);
        hl      = (sz > 0) && m_q[0].live;
        byp     = 0;
        e_a3    = 0;
        e_wd    = 0;
        if (reset) begin
            e_a3 = 0;
        end else if (pipe_a3 != 0) begin
            e_a3 = pipe_a3; e_wd = pipe_wd;
        end else if (hl) begin
            e_a3 = m_q[0].a3; e_wd = m_q[0].wd;
        end else if (sz == 0 && acc && lr_a3 != 0 && !squash) begin
            e_a3 = lr_a3; e_wd = lr_wd; byp = 1;
        end

        check_eq("lr_ready", 32'(obs_ready), 32'(e_ready));
        check_eq("grf_a3", 32'(obs_a3), 32'(e_a3));
        if (e_a3 != 0) check_eq("grf_wd", obs_wd, e_wd);
        check_eq("steal", 32'(obs_steal), 32'(m_steal));
        check_eq("pend1", 32'(obs_pend1), reset ? 32'd0 : 32'(model_pend(rd_a1)));
        check_eq("pend2", 32'(obs_pend2), reset ? 32'd0 : 32'(model_pend(rd_a2)));
        check_eq("count", obs_count, 32'(sz));

        if (reset) begin
            m_q.delete();
            m_starve = 0;
            m_steal  = 0;
        end else begin
            popped = (sz > 0) && (!hl || pipe_a3 == 0);
            nsteal = 0;
            if (sz == 0 || popped) begin
                m_starve = 0;
            end else begin
                m_starve++;
                if (m_starve == STARVE_MAX) begin
                    nsteal   = 1;
                    m_starve = 0;
                end
            end
            m_steal = nsteal;
            if (pipe_a3 != 0) foreach (m_q[i]) if (m_q[i].a3 == pipe_a3) m_q[i].live = 0;
            if (popped) void'(m_q.pop_front());
            if (acc && lr_a3 != 0 && !byp) m_q.push_back('{!squash, lr_a3, lr_wd});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        set_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_cycle();
        run_cycle();
        check_eq("rst_count", obs_count, 32'd0);
        check_eq("rst_ready", 32'(obs_ready), 32'd0);
        set_idle();
        run_cycle();
        check_eq("post_rst_ready", 32'(obs_ready), 32'd1);

        // Same-cycle bypass on an empty FIFO
        lr_valid = 1; lr_a3 = 5; lr_wd = 32'hDEADBEEF;
        run_cycle();
        check_eq("byp_a3", 32'(obs_a3), 32'd5);
        check_eq("byp_wd", obs_wd, 32'hDEADBEEF);
        check_eq("byp_count", obs_count, 32'd0);
        set_idle();
        run_cycle();
        check_eq("byp_not_stored", obs_count, 32'd0);

        // Starvation: pipe busy, two buffered results
        pipe_a3 = 3; pipe_wd = 32'h33;
        lr_valid = 1; lr_a3 = 7; lr_wd = 32'h77;
        run_cycle();
        lr_a3 = 8; lr_wd = 32'h88;
        run_cycle();
        lr_valid = 0; rd_a1 = 7;
        run_cycle();
        check_eq("stv_count", obs_count, 32'd2);
        check_eq("stv_ready", 32'(obs_ready), 32'd0);
        check_eq("stv_pend1", 32'(obs_pend1), 32'd1);
        for (int k = 0; k < 10 && !obs_steal; k++) run_cycle();
        check_eq("stv_steal_seen", 32'(obs_steal), 32'd1);
        pipe_a3 = 0;
        run_cycle();
        check_eq("stv_drain_a3", 32'(obs_a3), 32'd7);
        check_eq("stv_drain_wd", obs_wd, 32'h77);
        set_idle();
        run_cycle();
        check_eq("stv_drain2_a3", 32'(obs_a3), 32'd8);
        run_cycle();

        // Squash of a buffered entry
        pipe_a3 = 3; lr_valid = 1; lr_a3 = 9; lr_wd = 32'h11;
        run_cycle();
        lr_valid = 0; pipe_a3 = 9; pipe_wd = 32'h22; rd_a1 = 9;
        run_cycle();
        check_eq("sq_a3", 32'(obs_a3), 32'd9);
        check_eq("sq_wd", obs_wd, 32'h22);
        check_eq("sq_pend_before", 32'(obs_pend1), 32'd1);
        pipe_a3 = 3;
        run_cycle();
        check_eq("sq_pend_after", 32'(obs_pend1), 32'd0);
        check_eq("sq_count", obs_count, 32'd1);
        pipe_a3 = 0;
        run_cycle();
        check_eq("sq_killed_pop_a3", 32'(obs_a3), 32'd0);
        run_cycle();
        check_eq("sq_empty", obs_count, 32'd0);

        // Same-cycle conflict: lr and pipe both target r4
        pipe_a3 = 4; pipe_wd = 32'h44; lr_valid = 1; lr_a3 = 4; lr_wd = 32'h99; rd_a1 = 4;
        run_cycle();
        check_eq("cf_a3", 32'(obs_a3), 32'd4);
        check_eq("cf_wd", obs_wd, 32'h44);
        set_idle(); rd_a1 = 4;
        run_cycle();
        check_eq("cf_count", obs_count, 32'd1);
        check_eq("cf_pend", 32'(obs_pend1), 32'd0);
        check_eq("cf_a3_idle", 32'(obs_a3), 32'd0);
        run_cycle();

        // Simultaneous pop and push
        pipe_a3 = 3; lr_valid = 1; lr_a3 = 10; lr_wd = 32'hA0;
        run_cycle();
        pipe_a3 = 0; lr_a3 = 11; lr_wd = 32'hB0;
        run_cycle();
        check_eq("pp_a3", 32'(obs_a3), 32'd10);
        set_idle();
        run_cycle();
        check_eq("pp_count", obs_count, 32'd1);
        check_eq("pp_a3_next", 32'(obs_a3), 32'd11);
        run_cycle();

        // Reset with entries buffered and steal pending
        pipe_a3 = 3; lr_valid = 1; lr_a3 = 12; lr_wd = 32'hC0;
        run_cycle();
        lr_a3 = 13; lr_wd = 32'hD0;
        run_cycle();
        lr_valid = 0;
        for (int k = 0; k < 10 && !m_steal; k++) run_cycle();
        reset = 1;
        run_cycle();
        check_eq("rs_count_hold", obs_count, 32'd2);
        check_eq("rs_steal_hold", 32'(obs_steal), 32'd1);
        run_cycle();
        check_eq("rs_count", obs_count, 32'd0);
        check_eq("rs_steal", 32'(obs_steal), 32'd0);
        check_eq("rs_ready", 32'(obs_ready), 32'd0);
        check_eq("rs_a3", 32'(obs_a3), 32'd0);
        reset = 0;
        run_cycle();
        check_eq("rs_ready_after", 32'(obs_ready), 32'd1);

        // Random traffic, bubble honoured after steal
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 99) == 0);
            pipe_a3  = (obs_steal || $urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            pipe_wd  = $urandom;
            lr_valid = ($urandom_range(0, 9) < 6);
            lr_a3    = 5'($urandom_range(0, 7));
            lr_wd    = $urandom;
            rd_a1    = 5'($urandom_range(0, 7));
            rd_a2    = 5'($urandom_range(0, 7));
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
